// File: rtl/clk_40k_rx.sv
// clk_40k_rx: receive side of the 40 kHz rate clock, in the fast system domain.
// Synchronises clk_40k, emits a one-cycle sample strobe per rising edge,
// measures the edge-to-edge period, tracks lock, and captures one sample per
// locked strobe into a valid/ready holding register.
// Optional build macro: CLK40K_RX_STICKY_ERR_EN -- err holds from lock loss
// until the next entry into LOCKED (otherwise err is a one-cycle pulse).
module clk_40k_rx #(
  parameter int NOM_PERIOD = 250,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 14,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_40k,
  input  logic [DATA_W-1:0] din,
  input  logic              out_ready,
  output logic              sample_en,
  output logic              locked,
  output logic [CNT_W-1:0]  period,
  output logic              err,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              overrun
);

`ifdef CLK40K_RX_STICKY_ERR_EN
  localparam bit STICKY_ERR = 1'b1;
`else
  localparam bit STICKY_ERR = 1'b0;
`endif

  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(NOM_PERIOD + TOL);
  localparam int               GC_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [GC_W-1:0]  GC_LAST = GC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic              r_s1, r_s2, r_s3;
  logic              r_sample_en;
  logic [CNT_W-1:0]  r_pcnt;
  logic [CNT_W-1:0]  r_period;
  state_t            r_state;
  logic [GC_W-1:0]   r_good_cnt;
  logic              r_locked;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_rise;
  logic [CNT_W-1:0]  w_meas;
  logic              w_good;
  logic              w_timeout;
  logic              w_capture;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_meas    = (&r_pcnt) ? r_pcnt : r_pcnt + 1'b1;
  assign w_good    = (w_meas >= P_MIN) && (w_meas <= P_MAX);
  assign w_timeout = (w_meas > P_MAX);
  assign w_capture = r_sample_en & r_locked;

  // Two-flop synchroniser, edge-detect flop and registered sample strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_sample_en <= 1'b0;
    end else begin
      r_s1        <= clk_40k;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_sample_en <= w_rise;
    end
  end

  // Saturating period counter, restarted on every detected rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (w_rise) begin
      r_pcnt <= '0;
    end else if (!(&r_pcnt)) begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Lock FSM with registered period, locked and err outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= UNLOCK;
      r_good_cnt <= '0;
      r_period   <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (!STICKY_ERR) r_err <= 1'b0;
      case (r_state)
        UNLOCK: begin
          if (w_rise) begin
            r_state    <= ACQ;
            r_good_cnt <= '0;
          end
        end
        ACQ: begin
          if (w_rise) begin
            r_period <= w_meas;
            if (w_good) begin
              if (r_good_cnt == GC_LAST) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_err    <= 1'b0;
              end else begin
                r_good_cnt <= r_good_cnt + 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state <= UNLOCK;
          end
        end
        LOCKED: begin
          if (w_rise) r_period <= w_meas;
          if ((w_rise && !w_good) || (!w_rise && w_timeout)) begin
            r_state  <= UNLOCK;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: begin
          r_state  <= UNLOCK;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Sample holding register: capture on locked strobe, release on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_capture) begin
      r_dout      <= din;
      r_out_valid <= 1'b1;
      r_overrun   <= r_out_valid & ~out_ready;
    end else begin
      r_overrun <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign sample_en = r_sample_en;
  assign locked    = r_locked;
  assign period    = r_period;
  assign err       = r_err;
  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_clk_40k_rx.sv
// Directed bench for clk_40k_rx. Each driven rate-clock edge pushes the
// expected strobe (cycle, period, locked, err) to a queue; a monitor pops and
// compares whenever sample_en is seen, or when an expected strobe is overdue.
module tb_clk_40k_rx;
  localparam int DW = 16;
  localparam int CW = 14;

`ifdef CLK40K_RX_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_40k = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b1;
  logic          sample_en, locked, err, out_valid, overrun;
  logic [CW-1:0] period;
  logic [DW-1:0] dout;

  clk_40k_rx #(
    .NOM_PERIOD(250),
    .TOL(2),
    .LOCK_CNT(4),
    .CNT_W(CW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_40k(clk_40k),
    .din(din),
    .out_ready(out_ready),
    .sample_en(sample_en),
    .locked(locked),
    .period(period),
    .err(err),
    .dout(dout),
    .out_valid(out_valid),
    .overrun(overrun)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CW-1:0] per;
    logic          lk;
    logic          er;
  } exp_t;

  exp_t          sbq[$];
  int            n_assert = 0;
  int            n_fail = 0;
  int            last_rise = 0;
  logic [CW-1:0] exp_per = '0;
  logic          prev_lk = 1'b0;
  logic          sticky = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a rise now and return on the expected strobe cycle.
  task automatic start_edge(input logic first, input logic exp_lk, input logic loss);
    exp_t e;
    if (!first) exp_per = CW'(cyc - last_rise);
    last_rise = cyc;
    if (loss) sticky = 1'b1;
    if (exp_lk && !prev_lk) sticky = 1'b0;
    prev_lk = exp_lk;
    e.cyc = cyc + 3;
    e.per = exp_per;
    e.lk  = exp_lk;
    e.er  = STICKY ? sticky : loss;
    sbq.push_back(e);
    clk_40k = 1'b1;
    tick(3);
  endtask

  // Complete a period of n clocks (50% duty) measured from the last rise.
  task automatic finish_period(input int n);
    while (cyc < last_rise + n/2) @(negedge clk);
    clk_40k = 1'b0;
    while (cyc < last_rise + n) @(negedge clk);
  endtask

  task automatic per(input int n, input logic first, input logic exp_lk, input logic loss);
    start_edge(first, exp_lk, loss);
    finish_period(n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample_en"}, 32'(sample_en), 32'd0);
    chk({tag, "_locked"},    32'(locked),    32'd0);
    chk({tag, "_period"},    32'(period),    32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_dout"},      32'(dout),      32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  // Strobe monitor / scoreboard consumer
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && sample_en) begin
        if (sbq.size() == 0) begin
          chk("strobe_unexpected", 32'(sample_en), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("strobe_cycle",  32'(cyc),    32'(e.cyc));
          chk("strobe_period", 32'(period), 32'(e.per));
          chk("strobe_locked", 32'(locked), 32'(e.lk));
          chk("strobe_err",    32'(err),    32'(e.er));
        end
      end else if (sbq.size() != 0 && cyc >= sbq[0].cyc) begin
        chk("strobe_missing", 32'(sample_en), 32'd1);
        e = sbq.pop_front();
      end
    end
  end

  initial begin : watchdog
    #(100000 * 100);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick(3);
    check_zero("reset");
    rst = 1'b1;
    tick(5);

    // Acquire: restart edge plus four good periods
    per(250, 1'b1, 1'b0, 1'b0);
    repeat (3) per(250, 1'b0, 1'b0, 1'b0);
    per(250, 1'b0, 1'b1, 1'b0);
    per(248, 1'b0, 1'b1, 1'b0);
    per(252, 1'b0, 1'b1, 1'b0);
    per(253, 1'b0, 1'b1, 1'b0);

    // Period 253 loses lock
    start_edge(1'b0, 1'b0, 1'b1);
    tick(1);
    chk("loss_err_next", 32'(err), 32'(STICKY));
    chk("loss_locked_next", 32'(locked), 32'd0);
    finish_period(250);
    per(250, 1'b1, 1'b0, 1'b0);
    repeat (3) per(250, 1'b0, 1'b0, 1'b0);
    per(250, 1'b0, 1'b1, 1'b0);

    // Timeout with clk_40k held low
    start_edge(1'b0, 1'b1, 1'b0);
    while (cyc < last_rise + 125) @(negedge clk);
    clk_40k = 1'b0;
    while (cyc < last_rise + 255) @(negedge clk);
    chk("to_locked_before", 32'(locked), 32'd1);
    chk("to_err_before", 32'(err), 32'd0);
    tick(1);
    chk("to_locked", 32'(locked), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    tick(1);
    chk("to_err_next", 32'(err), 32'(STICKY));
    prev_lk = 1'b0;
    sticky  = 1'b1;
    tick(300);

    // Relock, then single capture with out_ready=1
    per(250, 1'b1, 1'b0, 1'b0);
    repeat (3) per(250, 1'b0, 1'b0, 1'b0);
    per(250, 1'b0, 1'b1, 1'b0);
    start_edge(1'b0, 1'b1, 1'b0);
    din = 16'h1234;
    tick(1);
    chk("cap_dout", 32'(dout), 32'h1234);
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_overrun", 32'(overrun), 32'd0);
    tick(1);
    chk("cap_valid_clr", 32'(out_valid), 32'd0);
    chk("cap_dout_hold", 32'(dout), 32'h1234);
    finish_period(250);

    // Overrun with out_ready=0 across two strobes
    out_ready = 1'b0;
    start_edge(1'b0, 1'b1, 1'b0);
    din = 16'hAAAA;
    tick(1);
    chk("ovr1_dout", 32'(dout), 32'hAAAA);
    chk("ovr1_valid", 32'(out_valid), 32'd1);
    chk("ovr1_overrun", 32'(overrun), 32'd0);
    finish_period(250);
    start_edge(1'b0, 1'b1, 1'b0);
    din = 16'h5555;
    tick(1);
    chk("ovr2_dout", 32'(dout), 32'h5555);
    chk("ovr2_valid", 32'(out_valid), 32'd1);
    chk("ovr2_overrun", 32'(overrun), 32'd1);
    tick(1);
    chk("ovr2_overrun_clr", 32'(overrun), 32'd0);
    chk("ovr2_valid_hold", 32'(out_valid), 32'd1);
    finish_period(250);
    start_edge(1'b0, 1'b1, 1'b0);
    din = 16'h0F0F;
    out_ready = 1'b1;
    tick(1);
    chk("rdy_dout", 32'(dout), 32'h0F0F);
    chk("rdy_overrun", 32'(overrun), 32'd0);
    chk("rdy_valid", 32'(out_valid), 32'd1);
    tick(1);
    chk("rdy_valid_clr", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    finish_period(250);

    // Lock loss keeps the pending sample; no capture while unlocked
    start_edge(1'b0, 1'b1, 1'b0);
    din = 16'hC3C3;
    tick(1);
    chk("pend_dout", 32'(dout), 32'hC3C3);
    finish_period(253);
    start_edge(1'b0, 1'b0, 1'b1);
    din = 16'hDEAD;
    tick(1);
    chk("unl_valid", 32'(out_valid), 32'd1);
    chk("unl_dout", 32'(dout), 32'hC3C3);
    chk("unl_overrun", 32'(overrun), 32'd0);
    finish_period(250);
    start_edge(1'b1, 1'b0, 1'b0);
    din = 16'hBEEF;
    tick(1);
    chk("acq_dout", 32'(dout), 32'hC3C3);
    chk("acq_valid", 32'(out_valid), 32'd1);
    finish_period(250);

    // Asynchronous reset mid-ACQ with a pending sample
    start_edge(1'b0, 1'b0, 1'b0);
    tick(50);
    #10;
    rst = 1'b0;
    clk_40k = 1'b0;
    #1;
    check_zero("async_rst");
    exp_per = '0;
    prev_lk = 1'b0;
    sticky  = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(5);
    check_zero("post_rst");

    // Full five-edge relock after reset
    per(250, 1'b1, 1'b0, 1'b0);
    repeat (3) per(250, 1'b0, 1'b0, 1'b0);
    per(250, 1'b0, 1'b1, 1'b0);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
